// File: rtl/fuec_pkg.sv
// FUEC(12,8) shared types and code definition.
// Data in [7:0], redundancy in [11:8].
package fuec_pkg;

  localparam int FUEC_N = 12;
  localparam int FUEC_K = 8;
  localparam int FUEC_R = 4;

  typedef logic [FUEC_N-1:0] fuec_cw_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    CHK,
    WR,
    NXT
  } scrub_state_e;

  // Syndrome column of each data bit: distinct, weight >= 2,
  // so redundancy-only flips never alias onto a data bit.
  localparam logic [FUEC_K-1:0][FUEC_R-1:0] FUEC_H = {
    4'b1011, 4'b0111, 4'b1100, 4'b1010,
    4'b1001, 4'b0110, 4'b0101, 4'b0011
  };

  function automatic logic [FUEC_R-1:0] fuec_red(
    input logic [FUEC_K-1:0] d
  );
    logic [FUEC_R-1:0] r;
    r = '0;
    for (int i = 0; i < FUEC_K; i++) begin
      if (d[i]) r = r ^ FUEC_H[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fuec_decoder_interface.sv
// FUEC(12,8) decoder: corrects a single data-bit error.
// pos_error_o flags the corrected data bit (one-hot).
module fuec_decoder_interface
  import fuec_pkg::*;
(
  input  logic [FUEC_N-1:0] cw_i,
  output logic [FUEC_K-1:0] data_o,
  output logic [FUEC_K-1:0] pos_error_o
);

  logic [FUEC_R-1:0] syn;

  always_comb begin
    syn = cw_i[FUEC_N-1:FUEC_K] ^ fuec_red(cw_i[FUEC_K-1:0]);
    pos_error_o = '0;
    for (int i = 0; i < FUEC_K; i++) begin
      pos_error_o[i] = (syn == FUEC_H[i]);
    end
    data_o = cw_i[FUEC_K-1:0] ^ pos_error_o;
  end

endmodule

// File: rtl/fuec_encoder_12_8.sv
// FUEC(12,8) encoder: redundancy nibble from 8 data bits.
// Purely combinational.
module fuec_encoder_12_8
  import fuec_pkg::*;
(
  input  logic [FUEC_K-1:0] data_i,
  output logic [FUEC_R-1:0] red_o
);

  assign red_o = fuec_red(data_i);

endmodule

// File: rtl/fuec_scrub_ctrl.sv
// Background scrubber: read, decode, re-encode and
// write back any FUEC(12,8) word that does not match.
module fuec_scrub_ctrl
  import fuec_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic [CNT_W-1:0]  data_fix_cnt,
  output logic [CNT_W-1:0]  par_fix_cnt,
  output logic [AW-1:0]     last_fix_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  scrub_state_e     state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  fuec_cw_t         rword_q, rword_d;
  fuec_cw_t         fixed_q, fixed_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [AW-1:0]    last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic             we_q, we_d;

  logic [FUEC_K-1:0] data_dec;
  logic [FUEC_K-1:0] pos_err;
  logic [FUEC_R-1:0] red_fix;
  fuec_cw_t          fixed;

  fuec_decoder_interface u_dec (
    .cw_i        (rword_q),
    .data_o      (data_dec),
    .pos_error_o (pos_err)
  );

  fuec_encoder_12_8 u_enc (
    .data_i (data_dec),
    .red_o  (red_fix)
  );

  assign fixed = {red_fix, data_dec};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rword_d = rword_q;
    fixed_d = fixed_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done_q marks the completion cycle; start there is dropped
        if (start && !done_q) begin
          state_d = RD;
          addr_d  = '0;
          dcnt_d  = '0;
          pcnt_d  = '0;
          last_d  = '0;
        end
      end
      RD: state_d = WT;
      WT: begin
        rword_d = mem_rdata;
        state_d = CHK;
      end
      CHK: begin
        fixed_d = fixed;
        state_d = (fixed != rword_q) ? WR : NXT;
      end
      WR: begin
        if (|pos_err) begin
          if (!(&dcnt_q)) dcnt_d = dcnt_q + CNT_W'(1);
        end else begin
          if (!(&pcnt_q)) pcnt_d = pcnt_q + CNT_W'(1);
        end
        last_d  = addr_q;
        state_d = NXT;
      end
      NXT: begin
        if (addr_q == LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!hold) begin
          addr_d  = addr_q + AW'(1);
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == RD) || (state_d == WR);
    we_d   = (state_d == WR);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rword_q <= '0;
      fixed_q <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rword_q <= rword_d;
      fixed_q <= fixed_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = fixed_q;
  assign data_fix_cnt  = dcnt_q;
  assign par_fix_cnt   = pcnt_q;
  assign last_fix_addr = last_q;

endmodule

// File: tb/tb_fuec_scrub_ctrl.sv
// Directed bench for fuec_scrub_ctrl: clean, data, redundancy,
// hold, reset, saturation and single-word passes.
module tb_fuec_scrub_ctrl;

  localparam logic [11:0] GOOD = 12'h8AC;

  logic clk = 1'b0;
  logic rst_n, start, hold, start_s, start_o, ld;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        busy, done, mem_req, mem_we;
  logic [7:0]  mem_addr, last_fix_addr;
  logic [11:0] mem_wdata, rdata;
  logic [15:0] data_fix_cnt, par_fix_cnt;

  logic        s_busy, s_done, s_req, s_we;
  logic [7:0]  s_addr, s_last;
  logic [11:0] s_wdata, s_rdata;
  logic [1:0]  s_dcnt, s_pcnt;

  logic        o_busy, o_done, o_req, o_we;
  logic [7:0]  o_addr, o_last;
  logic [11:0] o_wdata;
  logic [15:0] o_dcnt, o_pcnt;

  fuec_scrub_ctrl #(.AW(8), .DEPTH(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .busy(busy), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata),
    .data_fix_cnt(data_fix_cnt), .par_fix_cnt(par_fix_cnt),
    .last_fix_addr(last_fix_addr)
  );

  fuec_scrub_ctrl #(.AW(8), .DEPTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .hold(1'b0),
    .busy(s_busy), .done(s_done), .mem_req(s_req),
    .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .mem_rdata(s_rdata),
    .data_fix_cnt(s_dcnt), .par_fix_cnt(s_pcnt),
    .last_fix_addr(s_last)
  );

  fuec_scrub_ctrl #(.AW(8), .DEPTH(1), .CNT_W(16)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_o), .hold(1'b1),
    .busy(o_busy), .done(o_done), .mem_req(o_req),
    .mem_we(o_we), .mem_addr(o_addr),
    .mem_wdata(o_wdata), .mem_rdata(GOOD),
    .data_fix_cnt(o_dcnt), .par_fix_cnt(o_pcnt),
    .last_fix_addr(o_last)
  );

  logic [11:0] mem [16];
  logic [11:0] img [16];
  logic [11:0] mem_s [8];
  logic [11:0] img_s [8];

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
      for (int i = 0; i < 8; i++) mem_s[i] <= img_s[i];
    end else begin
      if (mem_req && mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      if (s_req && s_we) mem_s[s_addr[2:0]] <= s_wdata;
    end
    if (mem_req && !mem_we) rdata <= mem[mem_addr[3:0]];
    if (s_req && !s_we) s_rdata <= mem_s[s_addr[2:0]];
  end

  int          rd_addr[$];
  int          rd_cyc[$];
  int          wr_addr[$];
  logic [11:0] wr_data[$];
  int s_nrd = 0;
  int s_first = 0;
  int o_nrd = 0;
  int o_nwr = 0;
  int o_first = 0;

  always @(negedge clk) begin
    if (mem_req && !mem_we) begin
      rd_addr.push_back(int'(mem_addr));
      rd_cyc.push_back(cyc);
    end
    if (mem_req && mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
    if (s_req && !s_we) begin
      if (s_nrd == 0) s_first = cyc;
      s_nrd++;
    end
    if (o_req && !o_we) begin
      if (o_nrd == 0) o_first = cyc;
      o_nrd++;
    end
    if (o_req && o_we) o_nwr++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic commit();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic start_pass(output int rb, output int wb);
    rb = rd_addr.size();
    wb = wr_addr.size();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    check("done_seen", 32'(dc >= 0), 1);
  endtask

  int rb, wb, dc, n;
  int exp_a[4];

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    start_s = 1'b0; start_o = 1'b0; ld = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = GOOD;
    for (int i = 0; i < 8; i++) img_s[i] = GOOD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_dcnt", 32'(data_fix_cnt), 0);
    rst_n = 1'b1;

    // clean pass
    commit();
    start_pass(rb, wb);
    wait_done(300, dc);
    check("t1_reads", rd_addr.size() - rb, 16);
    check("t1_writes", wr_addr.size() - wb, 0);
    check("t1_cycles", dc - rd_cyc[rb], 64);
    check("t1_busy", 32'(busy), 0);
    check("t1_dcnt", 32'(data_fix_cnt), 0);
    check("t1_pcnt", 32'(par_fix_cnt), 0);

    // single data-bit flips at words 0..7
    for (int i = 0; i < 16; i++)
      img[i] = (i < 8) ? (GOOD ^ (12'd1 << i)) : GOOD;
    commit();
    start_pass(rb, wb);
    wait_done(300, dc);
    check("t2_writes", wr_addr.size() - wb, 8);
    for (int k = 0; k < 8; k++) begin
      check("t2_waddr", wr_addr[wb+k], k);
      check("t2_wdata", 32'(wr_data[wb+k]), 32'(GOOD));
    end
    check("t2_cycles", dc - rd_cyc[rb], 72);
    check("t2_dcnt", 32'(data_fix_cnt), 8);
    check("t2_pcnt", 32'(par_fix_cnt), 0);
    check("t2_last", 32'(last_fix_addr), 7);

    // redundancy flips
    exp_a = '{3, 5, 9, 12};
    for (int i = 0; i < 16; i++) img[i] = GOOD;
    for (int k = 0; k < 4; k++)
      img[exp_a[k]] = GOOD ^ (12'd1 << (8 + k));
    commit();
    start_pass(rb, wb);
    wait_done(300, dc);
    check("t3_writes", wr_addr.size() - wb, 4);
    for (int k = 0; k < 4; k++) begin
      check("t3_waddr", wr_addr[wb+k], exp_a[k]);
      check("t3_wdata", 32'(wr_data[wb+k]), 32'(GOOD));
    end
    check("t3_pcnt", 32'(par_fix_cnt), 4);
    check("t3_dcnt", 32'(data_fix_cnt), 0);
    check("t3_last", 32'(last_fix_addr), 12);

    // hold raised during CHK of address 2 for 10 cycles
    for (int i = 0; i < 16; i++) img[i] = GOOD;
    commit();
    fork
      begin
        start_pass(rb, wb);
        wait_done(400, dc);
      end
      begin
        n = 0;
        while (!(mem_req && !mem_we && mem_addr == 8'd2)
               && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("t4_arm", 32'(n < 100), 1);
        @(posedge clk);
        @(posedge clk);
        #1 hold = 1'b1;
        repeat (10) @(posedge clk);
        #1 hold = 1'b0;
      end
    join
    check("t4_reads", rd_addr.size() - rb, 16);
    check("t4_writes", wr_addr.size() - wb, 0);
    check("t4_next", rd_addr[rb+3], 3);
    check("t4_gap", rd_cyc[rb+3] - rd_cyc[rb+2], 13);
    check("t4_cycles", dc - rd_cyc[rb], 73);

    // reset asserted during the write of address 5
    for (int k = 0; k < 4; k++)
      img[exp_a[k]] = GOOD ^ (12'd1 << (8 + k));
    commit();
    start_pass(rb, wb);
    n = 0;
    while (!(mem_req && mem_we && mem_addr == 8'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_arm", 32'(n < 100), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 0);
    check("t5_req", 32'(mem_req), 0);
    check("t5_we", 32'(mem_we), 0);
    check("t5_addr", 32'(mem_addr), 0);
    check("t5_wdata", 32'(mem_wdata), 0);
    check("t5_pcnt", 32'(par_fix_cnt), 0);
    check("t5_last", 32'(last_fix_addr), 0);
    @(posedge clk);
    #1 check("t5_nowrite", 32'(mem[5]), 32'(GOOD ^ 12'h200));
    @(negedge clk) rst_n = 1'b1;
    start_pass(rb, wb);
    wait_done(300, dc);
    check("t5_first", rd_addr[rb], 0);
    check("t5_writes", wr_addr.size() - wb, 3);
    check("t5_waddr", wr_addr[wb], 5);
    check("t5_pcnt2", 32'(par_fix_cnt), 3);
    check("t5_dcnt2", 32'(data_fix_cnt), 0);
    check("t5_last2", 32'(last_fix_addr), 12);
    check("t5_fixed", 32'(mem[5]), 32'(GOOD));

    // saturation with CNT_W=2, restart attempt while busy
    for (int i = 0; i < 8; i++)
      img_s[i] = (i < 5) ? (GOOD ^ (12'd1 << i)) : GOOD;
    commit();
    @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    repeat (8) @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    dc = -1;
    for (int i = 0; i < 200 && dc < 0; i++) begin
      @(negedge clk);
      if (s_done) dc = cyc;
    end
    check("t6_done", 32'(dc >= 0), 1);
    check("t6_cycles", dc - s_first, 37);
    check("t6_reads", s_nrd, 8);
    check("t6_dcnt", 32'(s_dcnt), 3);
    check("t6_pcnt", 32'(s_pcnt), 0);
    check("t6_last", 32'(s_last), 4);

    // DEPTH=1 with hold tied high; start in the done cycle
    @(posedge clk);
    #1 start_o = 1'b1;
    @(posedge clk);
    #1 start_o = 1'b0;
    dc = -1;
    for (int i = 0; i < 50 && dc < 0; i++) begin
      @(negedge clk);
      if (o_done) dc = cyc;
    end
    check("t7_done", 32'(dc >= 0), 1);
    start_o = 1'b1;
    @(posedge clk);
    #1 start_o = 1'b0;
    check("t7_cycles", dc - o_first, 4);
    repeat (10) @(negedge clk);
    check("t7_reads", o_nrd, 1);
    check("t7_writes", o_nwr, 0);
    check("t7_busy", 32'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
